// File: rtl/lapido_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lapido_pkg
// Description : Shared Lapido constants: instruction width, PC step, fetch
//               state encoding and the instruction type-field codes that the
//               control unit decodes from bits [31:29].
// Revision    : 1.0 - initial release
// ============================================================================
package lapido_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int PC_STEP        = 4;

  // Type field position inside an instruction word
  localparam int TYPE_FIELD_MSB = 31;
  localparam int TYPE_FIELD_LSB = 29;

  // Instruction type-field codes consumed by control
  localparam logic [2:0] TYPE_ALU    = 3'd0;
  localparam logic [2:0] TYPE_ALUI   = 3'd1;
  localparam logic [2:0] TYPE_LOAD   = 3'd2;
  localparam logic [2:0] TYPE_STORE  = 3'd3;
  localparam logic [2:0] TYPE_BRANCH = 3'd4;
  localparam logic [2:0] TYPE_JUMP   = 3'd5;
  localparam logic [2:0] TYPE_SYSTEM = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2,
    FAULT    = 2'd3
  } fetch_state_e;

  // Extract the type field from an instruction word
  function automatic logic [2:0] instr_type(input logic [INSTR_WIDTH-1:0] instr);
    return instr[TYPE_FIELD_MSB:TYPE_FIELD_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch stage bus: instruction memory request/response plus the
//               instruction hand-off to control, stall and branch redirect.
//               master = fetch unit side, slave = memory/control side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
  import lapido_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                   imemReq;
  logic [ADDR_WIDTH-1:0]  imemAddr;
  logic                   imemReady;
  logic [INSTR_WIDTH-1:0] imemData;
  logic                   stall;
  logic                   branch;
  logic [ADDR_WIDTH-1:0]  branchTarget;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instrValid;
  logic [ADDR_WIDTH-1:0]  pcOut;
  logic                   fetchFault;

  modport master (
    output imemReq, imemAddr, instruction, instrValid, pcOut, fetchFault,
    input  imemReady, imemData, stall, branch, branchTarget
  );

  modport slave (
    input  imemReq, imemAddr, instruction, instrValid, pcOut, fetchFault,
    output imemReady, imemData, stall, branch, branchTarget
  );

endinterface
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter register. Asynchronous reset to RESET_PC,
//               load (redirect) has priority over increment (capture).
//               Increment wraps modulo 2^ADDR_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import lapido_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic                  load,
  input  wire logic [ADDR_WIDTH-1:0] load_value,
  input  wire logic                  incr,
  output logic      [ADDR_WIDTH-1:0] pc
);

  // PC update: redirect wins over sequential advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (incr) begin
      pc <= pc + ADDR_WIDTH'(PC_STEP);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Lapido instruction fetch stage. Owns the PC, issues word
//               reads, registers the returned instruction for control, and
//               handles branch redirects and downstream stalls.
//               Optional build macro: FETCH_ALIGN_CHECK_EN - a misaligned
//               branch target sends the unit to a terminal FAULT state
//               instead of silently clearing the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import lapido_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input wire logic      clock,
  input wire logic      reset,
  fetch_unit_if.master  bus
);

  fetch_state_e           state;
  fetch_state_e           state_next;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  target_word;
  logic                   req;
  logic                   branch_taken;
  logic                   capture;
  logic                   misaligned;
  logic [INSTR_WIDTH-1:0] instr_reg;
  logic                   instr_valid;
  logic [ADDR_WIDTH-1:0]  word_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned     = |bus.branchTarget[1:0];
  assign bus.fetchFault = (state == FAULT);
`else
  assign misaligned     = 1'b0;
  assign bus.fetchFault = 1'b0;
`endif

  // Redirects always land on a word boundary
  assign target_word = bus.branchTarget & ~ADDR_WIDTH'(3);

  // Branch beats a same-cycle memory response, so that word is dropped
  assign capture = req && bus.imemReady && !branch_taken;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, request and redirect decode
  always_comb begin
    state_next   = state;
    req          = 1'b0;
    branch_taken = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        req = !instr_valid || !bus.stall;
        if (bus.branch) begin
          branch_taken = 1'b1;
          state_next   = misaligned ? FAULT : REDIRECT;
        end
      end
      REDIRECT: begin
        state_next = FETCH;
        if (bus.branch) begin
          branch_taken = 1'b1;
          state_next   = misaligned ? FAULT : REDIRECT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clock      (clock),
    .reset      (reset),
    .load       (branch_taken),
    .load_value (target_word),
    .incr       (capture),
    .pc         (pc)
  );

  // Instruction holding register: flush on redirect, fill on capture,
  // empty once control consumes the word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_reg   <= '0;
      instr_valid <= 1'b0;
      word_pc     <= '0;
    end else if (branch_taken) begin
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr_reg   <= bus.imemData;
      word_pc     <= pc;
      instr_valid <= 1'b1;
    end else if (instr_valid && !bus.stall) begin
      instr_valid <= 1'b0;
    end
  end

  assign bus.imemReq     = req;
  assign bus.imemAddr    = pc;
  assign bus.instruction = instr_reg;
  assign bus.instrValid  = instr_valid;
  assign bus.pcOut       = word_pc;

endmodule
`default_nettype wire
